// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor: 2-bit saturating counter
// encodings, the counter values used at reset and on allocation, and the
// saturating next-state function.
// -----------------------------------------------------------------------------
package bp_pkg;

  // Counter encodings: the MSB is the taken/not-taken prediction.
  localparam logic [1:0] SNT = 2'd0;  // strong not-taken
  localparam logic [1:0] WNT = 2'd1;  // weak not-taken
  localparam logic [1:0] WT  = 2'd2;  // weak taken
  localparam logic [1:0] ST  = 2'd3;  // strong taken

  // Every entry starts weakly not-taken; a fresh allocation (only ever made
  // for a taken branch) starts weakly taken.
  localparam logic [1:0] CTR_RESET = WNT;
  localparam logic [1:0] CTR_ALLOC = WT;

  // Saturating step: never wraps from ST to SNT or from SNT to ST.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] next;
    if (taken) begin
      next = (ctr == ST) ? ST : ctr + 2'd1;
    end else begin
      next = (ctr == SNT) ? SNT : ctr - 2'd1;
    end
    return next;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// Pure combinational next-state function for one 2-bit saturating counter.
// Ports:
//   i_ctr       current counter value
//   i_taken     resolved branch outcome
//   o_ctr_next  counter value after training with i_taken
// -----------------------------------------------------------------------------
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr_next
);

  assign o_ctr_next = sat_update(i_ctr, i_taken);

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Fetch-side predictor: direct-mapped table of 2-bit saturating counters with
// a branch target buffer, trained by resolved branch outcomes from EX.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   lookup_pc          PC in IF; lookup is combinational
//   predict_taken      1 when the entry hits and its counter MSB is set
//   predict_target     stored target when predict_taken, else 0
//   update_valid       a conditional branch resolved in EX this cycle
//   update_pc          PC of the resolved branch
//   update_taken       resolved outcome
//   update_target      resolved target
//   update_predicted   prediction carried down the pipe with the branch
//   mispredict         registered; pulses the cycle after a wrong prediction
//
// Optional build macro BP_STATS_EN adds:
//   branch_count       number of resolved branches (wraps mod 2^32)
//   mispredict_count   number of mispredicted branches (wraps mod 2^32)
//
// Handshake: update_* is a one-cycle valid-only strobe; there is no ready,
// every cycle with update_valid=1 is consumed at the next rising edge and
// update_* are ignored entirely while update_valid=0.
// -----------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                predict_taken,
  output logic [PC_WIDTH-1:0] predict_target,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target,
  input  logic                update_predicted,
`ifdef BP_STATS_EN
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count,
`endif
  output logic                mispredict
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  // Table state
  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [PC_WIDTH-1:0] r_target [ENTRIES];
  logic                r_mispredict;

  // Lookup side
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic                  w_predict_taken;

  // Update side
  logic [INDEX_BITS-1:0] w_u_idx;
  logic [TAG_BITS-1:0]   w_u_tag;
  logic                  w_u_hit;
  logic [1:0]            w_u_ctr_next;
  logic                  w_u_wrong;

  // PC bits outside index/tag (word offset and high bits) do not take part.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[PC_WIDTH-1:TAG_HI+1],
                              update_pc[1:0], update_pc[PC_WIDTH-1:TAG_HI+1]};

  assign w_idx = lookup_pc[INDEX_BITS+1:2];
  assign w_tag = lookup_pc[TAG_HI:TAG_LO];

  // Reads the registered table only, so a same-cycle update is not bypassed.
  assign w_hit           = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_predict_taken = w_hit && r_ctr[w_idx][1];
  assign predict_taken   = w_predict_taken;
  assign predict_target  = w_predict_taken ? r_target[w_idx] : '0;

  assign w_u_idx   = update_pc[INDEX_BITS+1:2];
  assign w_u_tag   = update_pc[TAG_HI:TAG_LO];
  assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_wrong = update_taken != update_predicted;

  bp_sat_counter u_sat_counter (
    .i_ctr      (r_ctr[w_u_idx]),
    .i_taken    (update_taken),
    .o_ctr_next (w_u_ctr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_ctr[i]    <= CTR_RESET;
        r_target[i] <= '0;
      end
      r_mispredict <= 1'b0;
    end else begin
      // Gating by update_valid keeps junk on update_* out of the state.
      r_mispredict <= update_valid && w_u_wrong;
      if (update_valid) begin
        if (w_u_hit) begin
          r_ctr[w_u_idx] <= w_u_ctr_next;
          if (update_taken) begin
            r_target[w_u_idx] <= update_target;
          end
        end else if (update_taken) begin
          // Taken miss evicts whatever occupies the slot.
          r_valid[w_u_idx]  <= 1'b1;
          r_tag[w_u_idx]    <= w_u_tag;
          r_ctr[w_u_idx]    <= CTR_ALLOC;
          r_target[w_u_idx] <= update_target;
        end
      end
    end
  end

  assign mispredict = r_mispredict;

`ifdef BP_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (update_valid) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (w_u_wrong) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Drives directed and random lookup/update traffic into branch_predictor.
// The driver computes each cycle's expected outputs from a table model and
// pushes them into exp_q; the monitor pops and compares mid-cycle.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int EXP_W = 1 + 32 + 1 + 32 + 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_predicted;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
`endif

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .update_predicted (update_predicted),
`ifdef BP_STATS_EN
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
`endif
    .mispredict       (mispredict)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // 16 slots indexed by (pc/4) mod 16, tag (pc/64) mod 256, counter 0..3.
  bit          m_valid  [16];
  int          m_tag    [16];
  int          m_ctr    [16];
  logic [31:0] m_target [16];
  bit          m_mp;
  int unsigned m_bc;
  int unsigned m_mc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 0;
      m_tag[i]    = 0;
      m_ctr[i]    = 1;
      m_target[i] = 0;
    end
    m_mp = 0;
    m_bc = 0;
    m_mc = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt, input bit upred);
    int idx, tag, uidx, utag;
    bit hit, pt, uhit;
    logic [31:0] ptgt;
    @(negedge clk);
    lookup_pc    = lpc;
    update_valid = uv;
    if (uv) begin
      update_pc        = upc;
      update_taken     = ut;
      update_target    = utgt;
      update_predicted = upred;
    end else begin
      // Junk on ignored inputs.
      update_pc        = $urandom;
      update_taken     = 1'($urandom_range(0, 1));
      update_target    = $urandom;
      update_predicted = 1'($urandom_range(0, 1));
    end
    // Outputs during this cycle reflect the table before this update.
    idx  = int'((lpc / 4) % 16);
    tag  = int'((lpc / 64) % 256);
    hit  = m_valid[idx] && (m_tag[idx] == tag);
    pt   = hit && (m_ctr[idx] >= 2);
    ptgt = pt ? m_target[idx] : 32'h0;
    exp_q.push_back({pt, ptgt, m_mp, m_bc, m_mc});
    // Apply this cycle's update so the next cycle sees it.
    m_mp = uv && (ut != upred);
    if (uv) begin
      m_bc++;
      if (ut != upred) m_mc++;
      uidx = int'((upc / 4) % 16);
      utag = int'((upc / 64) % 256);
      uhit = m_valid[uidx] && (m_tag[uidx] == utag);
      if (uhit) begin
        if (ut) begin
          m_ctr[uidx]    = (m_ctr[uidx] + 1 > 3) ? 3 : m_ctr[uidx] + 1;
          m_target[uidx] = utgt;
        end else begin
          m_ctr[uidx] = (m_ctr[uidx] - 1 < 0) ? 0 : m_ctr[uidx] - 1;
        end
      end else if (ut) begin
        m_valid[uidx]  = 1;
        m_tag[uidx]    = utag;
        m_ctr[uidx]    = 2;
        m_target[uidx] = utgt;
      end
    end
  endtask

  task automatic idle(input logic [31:0] lpc);
    drive(lpc, 0, 32'h0, 0, 32'h0, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("predict_taken", 32'(predict_taken), 32'(e[97]));
        check("predict_target", predict_target, e[96:65]);
        check("mispredict", 32'(mispredict), 32'(e[64]));
`ifdef BP_STATS_EN
        check("branch_count", branch_count, e[63:32]);
        check("mispredict_count", mispredict_count, e[31:0]);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst              = 1'b1;
    lookup_pc        = 32'h40;
    update_valid     = 1'b0;
    update_pc        = 32'h0;
    update_taken     = 1'b0;
    update_target    = 32'h0;
    update_predicted = 1'b0;
    model_reset();
    #1;
    check("reset_taken", 32'(predict_taken), 32'h0);
    check("reset_target", predict_target, 32'h0);
    check("reset_mispredict", 32'(mispredict), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold allocate.
    drive(32'h40, 1, 32'h40, 1, 32'h100, 0);
    idle(32'h40);
    idle(32'h40);

    // Saturation and hysteresis at 0x40 (ctr currently 2).
    repeat (3) drive(32'h40, 1, 32'h40, 1, 32'h100, 1);
    repeat (4) drive(32'h40, 1, 32'h40, 0, 32'h0, 1);
    drive(32'h40, 1, 32'h40, 1, 32'h104, 0);
    drive(32'h40, 1, 32'h40, 1, 32'h108, 0);
    idle(32'h43);

    // Aliasing: 0x1040 shares the index with 0x40 but not the tag.
    drive(32'h40, 1, 32'h40, 1, 32'h120, 1);
    idle(32'h1040);
    drive(32'h1040, 1, 32'h1040, 1, 32'h500, 0);
    idle(32'h40);
    idle(32'h1040);

    // Same-cycle conflict: allocate 0x40 (ctr=2), then lookup while training NT.
    drive(32'h40, 1, 32'h40, 1, 32'h140, 0);
    drive(32'h40, 1, 32'h40, 0, 32'h0, 1);
    idle(32'h40);

    // Reset asserted mid-cycle while an update is being presented.
    drive(32'h0C, 1, 32'h0C, 1, 32'h200, 0);
    @(negedge clk);
    lookup_pc        = 32'h0C;
    update_valid     = 1'b1;
    update_pc        = 32'h0C;
    update_taken     = 1'b1;
    update_target    = 32'h300;
    update_predicted = 1'b0;
    #1;
    check("pre_rst_taken", 32'(predict_taken), 32'h1);
    check("pre_rst_mispredict", 32'(mispredict), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_async_taken", 32'(predict_taken), 32'h0);
    check("rst_async_target", predict_target, 32'h0);
    check("rst_async_mispredict", 32'(mispredict), 32'h0);
`ifdef BP_STATS_EN
    check("rst_async_branch_count", branch_count, 32'h0);
`endif
    @(negedge clk);
    update_valid = 1'b0;
    rst          = 1'b0;
    model_reset();

    // Five updates, two mispredicted; the miss/not-taken allocates nothing.
    drive(32'h80, 1, 32'h80, 0, 32'h0,   0);
    drive(32'h80, 1, 32'h84, 1, 32'h180, 0);
    drive(32'h84, 1, 32'h84, 1, 32'h184, 1);
    drive(32'h84, 1, 32'h84, 0, 32'h0,   1);
    drive(32'h80, 1, 32'h84, 1, 32'h188, 1);
    idle(32'h84);
`ifdef BP_STATS_EN
    #3;
    check("stats_branch_count", branch_count, 32'd5);
    check("stats_mispredict_count", mispredict_count, 32'd2);
`endif

    // Random traffic over a few tags and indices to force hits and evictions.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc, upc;
      lpc = {18'h0, 6'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      upc = {18'h0, 6'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      drive(lpc, 1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 1)),
            $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
    end
    idle(32'h0);

    // Drain the scoreboard with a bounded wait.
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
